// File: rtl/serial_adder_seq.sv
// Bit-serial add/subtract sequencer: one adder_carry cell is reused for every bit,
// LSB first, with the running carry kept in a flop between bits.

module adder_carry (
    input  logic p,
    input  logic g,
    input  logic cin,
    output logic sumout,
    output logic cout
);
    assign sumout = p ^ cin;
    assign cout   = g | (p & cin);
endmodule

module serial_adder_seq #(
    parameter int WIDTH = 16
) (
    input  logic             C,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] opa, opb, res, res_nx;
    logic             carry;
    logic [CW-1:0]    count;
    logic             p, g, sumout, cout, last;

    always_comb begin
        p = opa[count] ^ opb[count];
        g = opa[count] & opb[count];
    end

    adder_carry u_cell (
        .p      (p),
        .g      (g),
        .cin    (carry),
        .sumout (sumout),
        .cout   (cout)
    );

    assign last = (count == LAST);

    // Result with the current bit merged in, so the final step can publish all bits at once.
    always_comb begin
        res_nx        = res;
        res_nx[count] = sumout;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge C or negedge R) begin
        if (!R) state <= IDLE;
        else    state <= state_nx;
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            carry     <= 1'b0;
            count     <= '0;
            SUM       <= '0;
            COUT      <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= A;
                        opb   <= B ^ {WIDTH{SUB}};
                        carry <= SUB;
                        count <= '0;
                    end
                end
                RUN: begin
                    res   <= res_nx;
                    carry <= cout;
                    if (last) begin
                        count <= '0;
                        SUM   <= res_nx;
                        COUT  <= cout;
                        // Signed overflow: carry into the MSB differs from carry out of it.
                        OVF   <= carry ^ cout;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: an 8-bit and a 1-bit instance driven with
// directed and random transactions, compared against an arithmetic reference model.

module tb_serial_adder_seq;
    logic        C = 1'b0;
    logic        R = 1'b0;
    logic        iv   [2];
    logic        ordy [2];
    logic [63:0] a_tb [2];
    logic [63:0] b_tb [2];
    logic        sub_tb [2];
    logic        irdy [2];
    logic        ov   [2];
    logic        cout_o [2];
    logic        ovf_o  [2];
    logic [63:0] sum_o  [2];
    logic [63:0] last_sum [2];
    logic [7:0]  sum8;
    logic [0:0]  sum1;

    int errors = 0;
    int checks = 0;

    always #5 C = ~C;

    serial_adder_seq #(.WIDTH(8)) dut8 (
        .C(C), .R(R), .in_valid(iv[0]), .in_ready(irdy[0]),
        .A(a_tb[0][7:0]), .B(b_tb[0][7:0]), .SUB(sub_tb[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .SUM(sum8), .COUT(cout_o[0]), .OVF(ovf_o[0])
    );

    serial_adder_seq #(.WIDTH(1)) dut1 (
        .C(C), .R(R), .in_valid(iv[1]), .in_ready(irdy[1]),
        .A(a_tb[1][0:0]), .B(b_tb[1][0:0]), .SUB(sub_tb[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .SUM(sum1), .COUT(cout_o[1]), .OVF(ovf_o[1])
    );

    assign sum_o[0] = 64'(sum8);
    assign sum_o[1] = 64'(sum1);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum for SUM/COUT, true signed result range test for OVF.
    function automatic void model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic sub, output logic [63:0] s, output logic c,
                                  output logic o);
        logic [63:0] mask, a, b;
        logic [64:0] full;
        longint      sa, sb, r, lim;
        mask = (64'd1 << w) - 64'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        full = {1'b0, a} + {1'b0, sub ? (~b & mask) : b} + 65'(sub);
        s    = full[63:0] & mask;
        c    = full[w];
        lim  = longint'(1) << (w - 1);
        sa   = a[w-1] ? longint'(a) - (lim << 1) : longint'(a);
        sb   = b[w-1] ? longint'(b) - (lim << 1) : longint'(b);
        r    = sub ? sa - sb : sa + sb;
        o    = (r >= lim) || (r < -lim);
    endfunction

    // One full transaction on instance d; hold = cycles of out_ready=0 in DONE
    // with in_valid pulsed alongside fresh operands that must be ignored.
    task automatic txn(input int d, input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input int hold);
        int          w;
        int          n;
        logic [63:0] es, held;
        logic        ec, eo;
        w = (d == 0) ? 8 : 1;
        model(w, a, b, sub, es, ec, eo);
        n = 0;
        while (!irdy[d] && n < 50) begin
            @(posedge C); #1; n++;
        end
        check("in_ready_idle", 64'(irdy[d]), 64'd1);
        a_tb[d] = a; b_tb[d] = b; sub_tb[d] = sub; iv[d] = 1'b1;
        @(posedge C); #1;
        a_tb[d] = {$urandom, $urandom}; b_tb[d] = {$urandom, $urandom};
        sub_tb[d] = 1'($urandom); iv[d] = 1'($urandom);
        check("in_ready_run", 64'(irdy[d]), 64'd0);
        check("sum_kept_run", sum_o[d], last_sum[d]);
        n = 0;
        while (!ov[d] && n < 100) begin
            @(posedge C); #1; n++;
        end
        check("latency", 64'(n), 64'(w));
        check("sum", sum_o[d], es);
        check("cout", 64'(cout_o[d]), 64'(ec));
        check("ovf", 64'(ovf_o[d]), 64'(eo));
        held = sum_o[d];
        for (int i = 0; i < hold; i++) begin
            iv[d] = 1'b1; a_tb[d] = {$urandom, $urandom}; b_tb[d] = {$urandom, $urandom};
            @(posedge C); #1;
            check("bp_out_valid", 64'(ov[d]), 64'd1);
            check("bp_sum_stable", sum_o[d], held);
            check("bp_in_ready", 64'(irdy[d]), 64'd0);
        end
        iv[d] = 1'b0; ordy[d] = 1'b1;
        @(posedge C); #1;
        ordy[d] = 1'b0;
        check("out_valid_drop", 64'(ov[d]), 64'd0);
        check("in_ready_back", 64'(irdy[d]), 64'd1);
        check("sum_kept_idle", sum_o[d], es);
        last_sum[d] = es;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; a_tb[d] = '0; b_tb[d] = '0; sub_tb[d] = 1'b0;
            last_sum[d] = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", 64'(irdy[d]), 64'd1);
            check("rst_out_valid", 64'(ov[d]), 64'd0);
            check("rst_sum", sum_o[d], 64'd0);
            check("rst_cout", 64'(cout_o[d]), 64'd0);
            check("rst_ovf", 64'(ovf_o[d]), 64'd0);
        end
        R = 1'b1;
        @(posedge C); #1;

        // Directed WIDTH=8 cases
        txn(0, 64'h3C, 64'h15, 1'b0, 0);
        txn(0, 64'hFF, 64'h01, 1'b0, 0);
        txn(0, 64'h7F, 64'h01, 1'b0, 0);
        txn(0, 64'h10, 64'h20, 1'b1, 0);
        txn(0, 64'h80, 64'h01, 1'b1, 0);
        // Backpressure, then an immediate follow-on accept
        txn(0, 64'hA5, 64'h5A, 1'b0, 5);
        txn(0, 64'h00, 64'h01, 1'b1, 0);

        // Reset in the middle of RUN, asserted between clock edges
        a_tb[0] = 64'hC3; b_tb[0] = 64'h3C; sub_tb[0] = 1'b0; iv[0] = 1'b1;
        @(posedge C); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge C);
        #2 R = 1'b0;
        #1;
        check("abort_out_valid", 64'(ov[0]), 64'd0);
        check("abort_in_ready", 64'(irdy[0]), 64'd1);
        check("abort_sum", sum_o[0], 64'd0);
        check("abort_cout", 64'(cout_o[0]), 64'd0);
        @(posedge C); #1;
        R = 1'b1;
        last_sum[0] = '0;
        last_sum[1] = '0;
        repeat (12) begin
            @(posedge C); #1;
            check("abort_no_result", 64'(ov[0]), 64'd0);
        end
        txn(0, 64'h01, 64'h01, 1'b0, 0);

        // Directed WIDTH=1 cases
        txn(1, 64'h1, 64'h1, 1'b0, 0);
        txn(1, 64'h0, 64'h1, 1'b1, 0);

        // Random traffic on both instances
        for (int k = 0; k < 16; k++)
            txn(0, 64'($urandom), 64'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        for (int k = 0; k < 8; k++)
            txn(1, 64'($urandom), 64'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
